// File: rtl/spi_slave_frontend_pkg.sv
// Shared definitions for the SPI slave front end: FSM encoding, idle TX byte,
// synchronizer depth limits and a saturating add used by the statistics counters.
package spi_slave_frontend_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam logic [7:0] TX_IDLE_DEFAULT = 8'hFF;
  localparam int         SYNC_STAGES_MIN = 2;
  localparam int         SYNC_STAGES_MAX = 4;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one raw SPI pin; the reset value is an input so
// each pin can park at its own idle level.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{rst_val}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave front end: synchronized pins, byte shifter, one-entry RX and
// TX holding registers. Optional counters under SPI_SLAVE_FRONTEND_STATS_EN.
module spi_slave_frontend
  import spi_slave_frontend_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_IDLE     = TX_IDLE_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iSPI_SCLK,
  input  logic        iSPI_MOSI,
  input  logic        iSPI_CSn,
  output logic        oSPI_MISO,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_VALID,
  input  logic        iRX_READY,
  input  logic [7:0]  iTX_DATA,
  input  logic        iTX_VALID,
  output logic        oTX_READY,
  output logic        oBUSY,
  output logic        oOVERRUN,
  output logic        oUNDERRUN,
  output logic        oFRAME_ERR,
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
  output logic [15:0] oBYTE_CNT,
  output logic [7:0]  oERR_CNT,
`endif
  output spi_state_e  oDBG_STATE
);

  // Out-of-range depths are clamped rather than rejected.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam logic [2:0] FLUSH_LAST = 3'(SYNC_N + 1);

  logic sclk_s, mosi_s, cs_n_s;

  spi_pin_sync #(.STAGES(SYNC_N)) u_sync_sclk (
    .clk(iCLK), .rst_n(iRESETn), .rst_val(1'b0), .d(iSPI_SCLK), .q(sclk_s)
  );
  spi_pin_sync #(.STAGES(SYNC_N)) u_sync_mosi (
    .clk(iCLK), .rst_n(iRESETn), .rst_val(1'b0), .d(iSPI_MOSI), .q(mosi_s)
  );
  spi_pin_sync #(.STAGES(SYNC_N)) u_sync_csn (
    .clk(iCLK), .rst_n(iRESETn), .rst_val(1'b1), .d(iSPI_CSn), .q(cs_n_s)
  );

  spi_state_e state_q, state_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       cs_n_prev_q, cs_n_prev_d;
  logic       mosi_dly_q, mosi_dly_d;
  logic [2:0] flush_q, flush_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_done_q, rx_done_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       miso_q, miso_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic       frame_err_q, frame_err_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, flushed, tx_load;

  always_comb begin
    // Until the chains hold real pin samples, the CSn reset level could fake a falling edge.
    flushed   = (flush_q == FLUSH_LAST);
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_fall   = flushed & ~cs_n_s & cs_n_prev_q;
    cs_rise   = cs_n_s & ~cs_n_prev_q;

    state_d     = state_q;
    sclk_prev_d = sclk_s;
    cs_n_prev_d = cs_n_s;
    mosi_dly_d  = mosi_s;
    flush_d     = flushed ? flush_q : flush_q + 3'd1;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_done_d   = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    tx_shift_d  = tx_shift_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_load     = 1'b0;

    if (iTX_VALID && !tx_full_q) begin
      tx_hold_d = iTX_DATA;
      tx_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 3'd0;
          tx_load   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = 3'd0;
          frame_err_d = (bit_cnt_q != 3'd0);
          tx_shift_d  = TX_IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_dly_q};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          rx_done_d  = (bit_cnt_q == 3'd7);
        end else if (sclk_fall) begin
          // A fall with the counter back at zero follows the 8th rise: byte boundary.
          if (bit_cnt_q == 3'd0) begin
            tx_load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_hold_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = TX_IDLE;
        underrun_d = 1'b1;
      end
    end

    if (rx_valid_q && iRX_READY) begin
      rx_valid_d = 1'b0;
    end
    if (rx_done_q) begin
      if (rx_valid_q && !iRX_READY) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end

    miso_d = (state_d == ST_SHIFT) ? tx_shift_d[7] : 1'b1;
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      mosi_dly_q  <= 1'b0;
      flush_q     <= 3'd0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_done_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_hold_q   <= 8'h00;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= TX_IDLE;
      miso_q      <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
      mosi_dly_q  <= mosi_dly_d;
      flush_q     <= flush_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_done_q   <= rx_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign oSPI_MISO  = miso_q;
  assign oRX_DATA   = rx_data_q;
  assign oRX_VALID  = rx_valid_q;
  assign oTX_READY  = ~tx_full_q;
  assign oBUSY      = busy_q;
  assign oOVERRUN   = overrun_q;
  assign oUNDERRUN  = underrun_q;
  assign oFRAME_ERR = frame_err_q;
  assign oDBG_STATE = state_q;

`ifdef SPI_SLAVE_FRONTEND_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;

  always_comb begin
    err_inc   = {1'b0, overrun_d} + {1'b0, underrun_d} + {1'b0, frame_err_d};
    err_cnt_d = sat_add8(err_cnt_q, err_inc);
    if (state_q == ST_IDLE && cs_fall) begin
      byte_cnt_d = 16'd0;
    end else if (rx_done_q) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      byte_cnt_q <= 16'd0;
      err_cnt_q  <= 8'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign oBYTE_CNT = byte_cnt_q;
  assign oERR_CNT  = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: a bit-banged mode-0 master drives six
// scenarios, with expected bytes and event counts worked out by hand.
module tb_spi_slave_frontend;
  import spi_slave_frontend_pkg::*;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy, overrun, underrun, frame_err;
  spi_state_e dbg_state;
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
  logic [15:0] byte_cnt;
  logic [7:0]  err_cnt;
`endif

  // Clock/reset
  always #5 clk = ~clk;

  spi_slave_frontend dut (
    .iCLK(clk), .iRESETn(rst_n),
    .iSPI_SCLK(spi_sclk), .iSPI_MOSI(spi_mosi), .iSPI_CSn(spi_cs_n),
    .oSPI_MISO(spi_miso),
    .oRX_DATA(rx_data), .oRX_VALID(rx_valid), .iRX_READY(rx_ready),
    .iTX_DATA(tx_data), .iTX_VALID(tx_valid), .oTX_READY(tx_ready),
    .oBUSY(busy), .oOVERRUN(overrun), .oUNDERRUN(underrun), .oFRAME_ERR(frame_err),
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
    .oBYTE_CNT(byte_cnt), .oERR_CNT(err_cnt),
`endif
    .oDBG_STATE(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int ovr_n = 0;
  int udr_n = 0;
  int ferr_n = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Monitor: event pulses and accepted RX bytes
  always @(negedge clk) begin
    if (overrun)   ovr_n++;
    if (underrun)  udr_n++;
    if (frame_err) ferr_n++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic tx_preload(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
  endtask

  // Shifts nbits MSB-first; with end_frame the last SCLK fall and CSn rise coincide.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit end_frame,
                          input bit rdy_pulse, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      wait_clks(HALF);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      for (int j = 0; j < HALF; j++) begin
        @(negedge clk);
        if (rdy_pulse && i == 0) rx_ready = (j == 2);
      end
      spi_sclk = 1'b0;
      if (end_frame && i == 8 - nbits) spi_cs_n = 1'b1;
    end
    if (end_frame) wait_clks(8);
  endtask

  initial begin
    logic [7:0] m0, m1;
    int base_o, base_u, base_f, base_g;

    // Reset values
    wait_clks(3);
    chk("rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("rst_rx_data", 16'(rx_data), 16'h0);
    chk("rst_tx_ready", 16'(tx_ready), 16'h1);
    chk("rst_miso", 16'(spi_miso), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_pulses", 16'({overrun, underrun, frame_err}), 16'h0);
    chk("rst_state", 16'(dbg_state), 16'(ST_IDLE));
    rst_n = 1'b1;
    wait_clks(8);

    // Scenario 1: A5 in, 3C out
    base_u = udr_n;
    tx_preload(8'h3C);
    wait_clks(1);
    chk("s1_tx_full", 16'(tx_ready), 16'h0);
    cs_low();
    chk("s1_busy", 16'(busy), 16'h1);
    chk("s1_state", 16'(dbg_state), 16'(ST_SHIFT));
    chk("s1_tx_loaded", 16'(tx_ready), 16'h1);
    spi_bits(8'hA5, 8, 1'b1, 1'b0, m0);
    chk("s1_miso", 16'(m0), 16'h3C);
    chk("s1_rx_valid", 16'(rx_valid), 16'h1);
    chk("s1_rx_data", 16'(rx_data), 16'hA5);
    chk("s1_underrun", 16'(udr_n - base_u), 16'h0);
    chk("s1_busy_end", 16'(busy), 16'h0);
    chk("s1_miso_idle", 16'(spi_miso), 16'h1);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(1);
    chk("s1_drained", 16'(rx_valid), 16'h0);

    // Scenario 2: overruns with ready low, then accept-and-load in one cycle
    base_o = ovr_n;
    cs_low();
    spi_bits(8'h11, 8, 1'b0, 1'b0, m0);
    spi_bits(8'h22, 8, 1'b0, 1'b0, m0);
    spi_bits(8'h33, 8, 1'b1, 1'b0, m0);
    chk("s2_rx_valid", 16'(rx_valid), 16'h1);
    chk("s2_rx_data", 16'(rx_data), 16'h11);
    chk("s2_overruns", 16'(ovr_n - base_o), 16'h2);
    cs_low();
    spi_bits(8'h44, 8, 1'b1, 1'b1, m0);
    chk("s2_same_cycle_valid", 16'(rx_valid), 16'h1);
    chk("s2_same_cycle_data", 16'(rx_data), 16'h44);
    chk("s2_same_cycle_no_ovr", 16'(ovr_n - base_o), 16'h2);
    rx_ready = 1'b1;
    wait_clks(2);

    // Scenario 3: underruns
    base_u = udr_n;
    cs_low();
    spi_bits(8'h00, 8, 1'b0, 1'b0, m0);
    spi_bits(8'h00, 8, 1'b1, 1'b0, m1);
    chk("s3_miso0", 16'(m0), 16'hFF);
    chk("s3_miso1", 16'(m1), 16'hFF);
    chk("s3_underruns", 16'(udr_n - base_u), 16'h2);

    // Scenario 4: frame error after 5 bits, then a clean frame
    base_f = ferr_n;
    base_g = got_q.size();
    cs_low();
    spi_bits(8'hFF, 5, 1'b1, 1'b0, m0);
    chk("s4_frame_err", 16'(ferr_n - base_f), 16'h1);
    chk("s4_no_rx", 16'(got_q.size() - base_g), 16'h0);
    chk("s4_rx_valid", 16'(rx_valid), 16'h0);
    cs_low();
    spi_bits(8'h5A, 8, 1'b1, 1'b0, m0);
    chk("s4_next_count", 16'(got_q.size() - base_g), 16'h1);
    chk("s4_next_data", 16'(got_q[got_q.size() - 1]), 16'h5A);
    chk("s4_frame_err_once", 16'(ferr_n - base_f), 16'h1);

    // Scenario 5: reset mid-byte
    base_f = ferr_n;
    rx_ready = 1'b0;
    cs_low();
    tx_preload(8'h77);
    spi_bits(8'hA5, 4, 1'b0, 1'b0, m0);
    spi_sclk = 1'b1;
    wait_clks(2);
    rst_n = 1'b0;
    #1;
    chk("s5_rx_valid", 16'(rx_valid), 16'h0);
    chk("s5_rx_data", 16'(rx_data), 16'h0);
    chk("s5_tx_ready", 16'(tx_ready), 16'h1);
    chk("s5_miso", 16'(spi_miso), 16'h1);
    chk("s5_busy", 16'(busy), 16'h0);
    chk("s5_state", 16'(dbg_state), 16'(ST_IDLE));
    wait_clks(1);
    rst_n = 1'b1;
    spi_sclk = 1'b0;
    rx_ready = 1'b1;
    wait_clks(10);
    chk("s5_no_fake_frame", 16'(busy), 16'h0);
    chk("s5_no_frame_err", 16'(ferr_n - base_f), 16'h0);
    spi_cs_n = 1'b1;
    wait_clks(8);
    base_g = got_q.size();
    cs_low();
    spi_bits(8'hC3, 8, 1'b1, 1'b0, m0);
    chk("s5_next_count", 16'(got_q.size() - base_g), 16'h1);
    chk("s5_next_data", 16'(got_q[got_q.size() - 1]), 16'hC3);

    // Scenario 6: 256-byte stream at SCLK = clk/8, scoreboarded
    base_o = ovr_n;
    base_g = got_q.size();
    for (int b = 0; b < 256; b++) exp_q.push_back(8'(b));
    cs_low();
    for (int b = 0; b < 256; b++) spi_bits(8'(b), 8, b == 255, 1'b0, m0);
    chk("s6_count", 16'(got_q.size() - base_g), 16'd256);
    chk("s6_no_overrun", 16'(ovr_n - base_o), 16'h0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (base_g + k < got_q.size()) chk("s6_byte", 16'(got_q[base_g + k]), 16'(e));
      else chk("s6_byte_missing", 16'hDEAD, 16'(e));
    end
`ifdef SPI_SLAVE_FRONTEND_STATS_EN
    chk("s6_byte_cnt", byte_cnt, 16'd256);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
